// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared conv pipeline scheduler types and default geometry
package conv_pkg;

    localparam int CONV_CHAN = 10;
    localparam int CONV_CH_W = 4;

    // Bit positions inside the sticky err vector
    localparam int ERR_TAG = 0;
    localparam int ERR_TMO = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/conv_sched_wdog.sv
// rtl/conv_sched_wdog.sv - WAIT-state watchdog; expire flags WDOG_CYC-1 counted cycles
module conv_sched_wdog #(
    parameter int WDOG_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

    logic [CW-1:0] cnt_q;

    // Counter parks on the terminal value; the scheduler leaves WAIT on expire
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == CW'(WDOG_CYC - 1));

endmodule

// File: rtl/conv_chan_sched.sv
// rtl/conv_chan_sched.sv - per-channel pass scheduler for conv1->conv2; CONV_SCHED_WDOG_EN adds WAIT timeout
module conv_chan_sched
    import conv_pkg::*;
#(
    parameter int CHAN     = CONV_CHAN,
    parameter int CH_W     = CONV_CH_W,
    parameter int WDOG_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            conv_valid,
    input  logic [CH_W-1:0] conv_chan,
    output logic            conv_trig,
    output logic [CH_W-1:0] wsel,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err
);

    sched_state_e    state_q;
    logic [CH_W-1:0] chan_q;
    logic [CH_W-1:0] wsel_q;
    logic            trig_q;
    logic            clr_q;
    logic            en_q;
    logic            busy_q;
    logic            done_q;
    logic [1:0]      err_q;

    logic last_chan;
    logic tag_bad;
    logic tmo;

    assign last_chan = (chan_q == CH_W'(CHAN - 1));
    assign tag_bad   = (conv_chan != chan_q);

`ifdef CONV_SCHED_WDOG_EN
    logic wdog_expire;

    conv_sched_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ISSUE),
        .en     (state_q == WAIT),
        .expire (wdog_expire)
    );

    // A result landing on the final count cycle takes priority over the timeout
    assign tmo = (state_q == WAIT) && wdog_expire && !conv_valid;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYC;
    assign tmo         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
            wsel_q  <= '0;
            trig_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            trig_q <= 1'b0;
            clr_q  <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                chan_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            state_q <= ISSUE;
                            clr_q   <= 1'b1;
                            err_q   <= 2'b00;
                            chan_q  <= '0;
                            wsel_q  <= '0;
                            trig_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                        if (conv_valid) begin
                            err_q[ERR_TAG] <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        state_q <= WAIT;
                        if (conv_valid) begin
                            err_q[ERR_TAG] <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (conv_valid) begin
                            en_q <= 1'b1;
                            if (tag_bad) begin
                                err_q[ERR_TAG] <= 1'b1;
                            end
                            if (last_chan) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ISSUE;
                                chan_q  <= chan_q + 1'b1;
                                wsel_q  <= chan_q + 1'b1;
                                trig_q  <= 1'b1;
                            end
                        end else if (tmo) begin
                            err_q[ERR_TMO] <= 1'b1;
                            state_q        <= DONE;
                            done_q         <= 1'b1;
                            busy_q         <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        if (conv_valid) begin
                            err_q[ERR_TAG] <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign conv_trig = trig_q;
    assign wsel      = wsel_q;
    assign acc_clr   = clr_q;
    assign acc_en    = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_chan_sched.sv
// tb/tb_conv_chan_sched.sv - randomized scoreboard bench for conv_chan_sched
module tb_conv_chan_sched;

    localparam int CHAN = 10;
    localparam int CH_W = 4;
    localparam int WDOG = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic            conv_valid;
    logic [CH_W-1:0] conv_chan;
    logic            conv_trig;
    logic [CH_W-1:0] wsel;
    logic            acc_clr;
    logic            acc_en;
    logic            busy;
    logic            done;
    logic [1:0]      err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int trig_cyc_q[$];
    int trig_ch_q[$];
    int acc_q[$];
    int clr_q[$];
    int done_cyc_q[$];
    int done_err_q[$];

    conv_chan_sched #(
        .CHAN     (CHAN),
        .CH_W     (CH_W),
        .WDOG_CYC (WDOG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .conv_valid (conv_valid),
        .conv_chan  (conv_chan),
        .conv_trig  (conv_trig),
        .wsel       (wsel),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_expect();
        trig_cyc_q.delete();
        trig_ch_q.delete();
        acc_q.delete();
        clr_q.delete();
        done_cyc_q.delete();
        done_err_q.delete();
    endtask

    // Monitor: every observed output pulse consumes one scoreboard entry
    task automatic monitor_step();
        int ec;
        int ev;
        if (conv_trig) begin
            check("trig_pending", int'(trig_cyc_q.size() > 0), 1);
            if (trig_cyc_q.size() > 0) begin
                ec = trig_cyc_q.pop_front();
                ev = trig_ch_q.pop_front();
                check("trig_cycle", cyc, ec);
                check("trig_wsel", int'(wsel), ev);
                check("trig_busy", int'(busy), 1);
            end
        end
        if (acc_en) begin
            check("acc_pending", int'(acc_q.size() > 0), 1);
            if (acc_q.size() > 0) begin
                ec = acc_q.pop_front();
                check("acc_cycle", cyc, ec);
            end
        end
        if (acc_clr) begin
            check("clr_pending", int'(clr_q.size() > 0), 1);
            if (clr_q.size() > 0) begin
                ec = clr_q.pop_front();
                check("clr_cycle", cyc, ec);
                check("clr_err", int'(err), 0);
            end
        end
        if (done) begin
            check("done_pending", int'(done_cyc_q.size() > 0), 1);
            if (done_cyc_q.size() > 0) begin
                ec = done_cyc_q.pop_front();
                ev = done_err_q.pop_front();
                check("done_cycle", cyc, ec);
                check("done_err", int'(err), ev);
                check("done_busy", int'(busy), 0);
            end
        end
    endtask

    always @(negedge clk) if (!rst) monitor_step();

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (conv_trig) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("trig_seen", int'(conv_trig), 1);
    endtask

    // Reference timing: trigger k+1 (and acc_en k) land lat[k]+1 cycles after trigger k
    task automatic run_job(input int lat_fixed, input int bad_pass, input int abort_pass,
                           input int rst_pass, input bit spur);
        int lat[CHAN];
        int s;
        int t;
        int stop;
        int exp_err;
        bit ok;
        stop = CHAN;
        if (abort_pass >= 0) stop = abort_pass;
        if (rst_pass >= 0) stop = rst_pass;
        for (int k = 0; k < CHAN; k++) begin
            lat[k] = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
        end
        exp_err = (bad_pass >= 0 && bad_pass < stop) ? 1 : 0;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        clr_q.push_back(s + 1);
        t = s + 1;
        for (int k = 0; k < CHAN; k++) begin
            trig_cyc_q.push_back(t);
            trig_ch_q.push_back(k);
            if (k == stop) break;
            t = t + lat[k] + 1;
            acc_q.push_back(t);
        end
        if (stop == CHAN) begin
            done_cyc_q.push_back(t);
            done_err_q.push_back(exp_err);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < CHAN; k++) begin
            wait_trig(ok);
            if (!ok) begin
                flush_expect();
                return;
            end
            if (k == rst_pass) begin
                @(negedge clk);
                rst = 1'b1;
                flush_expect();
                @(negedge clk);
                check("rst_outputs", int'({conv_trig, wsel, acc_clr, acc_en, busy, done, err}), 0);
                rst = 1'b0;
                return;
            end
            repeat (lat[k]) @(negedge clk);
            conv_valid = 1'b1;
            conv_chan  = (k == bad_pass) ? CH_W'((k + 1) % CHAN) : CH_W'(k);
            if (k == abort_pass) abort = 1'b1;
            if (spur && k == CHAN / 2) start = 1'b1;
            @(negedge clk);
            conv_valid = 1'b0;
            abort      = 1'b0;
            start      = 1'b0;
            if (k == abort_pass) begin
                check("abort_busy", int'(busy), 0);
                check("abort_err", int'(err), exp_err);
                repeat (3) @(negedge clk);
                check("abort_idle_busy", int'(busy), 0);
                return;
            end
        end
        if (spur) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_done_err", int'(err), exp_err);
        check("post_done_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

`ifdef CONV_SCHED_WDOG_EN
    task automatic run_wdog();
        int s;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        clr_q.push_back(s + 1);
        trig_cyc_q.push_back(s + 1);
        trig_ch_q.push_back(0);
        done_cyc_q.push_back(s + 2 + WDOG);
        done_err_q.push_back(2);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4 * WDOG; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("wdog_done_seen", int'(done), 1);
        @(negedge clk);
        check("wdog_err", int'(err), 2);
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        conv_valid = 1'b0;
        conv_chan  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", int'({conv_trig, wsel, acc_clr, acc_en, busy, done, err}), 0);

        run_job(5, -1, -1, -1, 1'b0);
        run_job(0, 2, -1, -1, 1'b0);
        run_job(0, -1, -1, -1, 1'b0);
        run_job(0, 1, 4, -1, 1'b0);
        run_job(0, -1, 4, -1, 1'b0);

        // Late result from the aborted pass shows up as spurious
        check("pre_spur_err", int'(err), 0);
        @(negedge clk);
        conv_valid = 1'b1;
        conv_chan  = CH_W'($urandom_range(0, CHAN - 1));
        @(negedge clk);
        conv_valid = 1'b0;
        check("spur_err", int'(err), 1);

        run_job(0, -1, -1, -1, 1'b1);
        run_job(0, -1, -1, 3, 1'b0);
        run_job(0, -1, -1, -1, 1'b0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        check("abort_wins_idle", int'(busy), 0);

`ifdef CONV_SCHED_WDOG_EN
        run_wdog();
        run_job(0, -1, -1, -1, 1'b0);
`endif

        for (int j = 0; j < 6; j++) begin
            run_job(0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, CHAN - 1)) : -1,
                    -1, -1, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("leftover_events",
              trig_cyc_q.size() + acc_q.size() + clr_q.size() + done_cyc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
